// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg
//   Shared definitions for the ALU and the multiply sequencer that borrows it.
//   - ALU_* : 3-bit ALUControl encodings understood by the ALU.
//   - seq_state_t : multiply sequencer FSM states.
package mips_alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Iterative shift-and-add multiplier that borrows the shared ALU. It produces
//   the low WIDTH bits of op_a*op_b, which is the same for signed and unsigned
//   operands. One ALU add is issued per RUN cycle; the sum is taken back from
//   alu_result in the same cycle.
//
//   Build option: define MUL_EARLY_TERM_EN to stop as soon as the remaining
//   multiplier bits are all zero. Products are identical either way; only the
//   latency changes.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 request, sampled only in IDLE or DONE
//   op_a, op_b            multiplicand / multiplier, captured on accept
//   busy                  high in RUN, stalls the core
//   done                  one-cycle pulse, product valid
//   product               result, held until overwritten by the next multiply
//   alu_own               high in RUN, steers the ALU input muxes to us
//   alu_srca, alu_srcb    ALU operand drives (zero outside RUN)
//   alu_control           ALU control drive (zero outside RUN)
//   alu_result            ALU result, combinational
module alu_mul_sequencer
    import mips_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result
);

    seq_state_t       state_q;
    logic             busy_q, done_q, own_q;
    logic [WIDTH-1:0] product_q, acc_q, m_q, q_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_iter;

    // The early-exit test looks at the multiplier after this cycle's shift:
    // once nothing is left to add, the accumulator already holds the product.
`ifdef MUL_EARLY_TERM_EN
    assign last_iter = (cnt_q == CNT_W'(WIDTH-1)) || (q_q[WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt_q == CNT_W'(WIDTH-1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            own_q     <= 1'b0;
            product_q <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        own_q   <= 1'b1;
                        m_q     <= op_a;
                        q_q     <= op_b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        own_q   <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q <= alu_result;
                    m_q   <= m_q << 1;
                    q_q   <= q_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        state_q   <= DONE;
                        product_q <= alu_result;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        own_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    own_q   <= 1'b0;
                end
            endcase
        end
    end

    // ALU drives are quiet outside RUN so the muxed ALU sees clean zeros.
    always_comb begin
        alu_srca    = '0;
        alu_srcb    = '0;
        alu_control = 3'b000;
        if (state_q == RUN) begin
            alu_srca    = acc_q;
            alu_srcb    = q_q[0] ? m_q : '0;
            alu_control = ALU_ADD;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign alu_own = own_q;
    assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Testbench for alu_mul_sequencer with a reference ALU on the alu_* ports.
// Expected products and done cycles are queued at issue time; a monitor
// compares them whenever done pulses. Define MUL_EARLY_TERM_EN to match
// an RTL built with early termination.
module tb_alu_mul_sequencer;
    import mips_alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] op_a, op_b, product, alu_srca, alu_srcb, alu_result;
    logic         busy, done, alu_own;
    logic [2:0]   alu_control;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] prod;
        int           cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [W-1:0] a, b, prod;
        int           it_early;
    } vec_t;

    alu_mul_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product(product), .alu_own(alu_own),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_control(alu_control),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU
    always_comb begin
        case (alu_control)
            ALU_AND: alu_result = alu_srca & alu_srcb;
            ALU_OR:  alu_result = alu_srca | alu_srcb;
            ALU_ADD: alu_result = alu_srca + alu_srcb;
            ALU_SUB: alu_result = alu_srca - alu_srcb;
            ALU_SLT: alu_result = {{(W-1){1'b0}}, $signed(alu_srca) < $signed(alu_srcb)};
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int iters(input int it_early);
`ifdef MUL_EARLY_TERM_EN
        return it_early;
`else
        return W;
`endif
    endfunction

    // Monitor: every done pulse must match the head of the scoreboard.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", product, e.prod);
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("busy_in_done", 32'(busy), 32'd0);
            end
            if (done_prev) check("done_width", 32'(done_prev), 32'd0);
        end
        done_prev <= done;
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] prod, input int it_early);
        exp_t e;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        e.prod = prod;
        e.cyc  = cyc + iters(it_early) + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        check("busy_run", 32'(busy), 32'd1);
        check("own_run", 32'(alu_own), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_quiet();
        @(negedge clk);
        check("idle_own", 32'(alu_own), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_srca", alu_srca, 32'd0);
        check("idle_srcb", alu_srcb, 32'd0);
        check("idle_ctl", 32'(alu_control), 32'd0);
    endtask

    vec_t vecs[8] = '{
        '{32'd7,         32'd6,         32'd42,        3},
        '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32},
        '{32'hFFFF_FFFB, 32'd3,         32'hFFFF_FFF1, 2},
        '{32'd5,         32'd0,         32'd0,         1},
        '{32'd5,         32'd8,         32'd40,        4},
        '{32'd9,         32'd1,         32'd9,         1},
        '{32'h1234_5678, 32'h10,        32'h2345_6780, 5},
        '{32'h8000_0000, 32'd2,         32'd0,         2}
    };

    initial begin
        int c;
        exp_t e;
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_own", 32'(alu_own), 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_ctl", 32'(alu_control), 32'd0);
        reset = 1'b0;

        // Directed multiplies
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].it_early);
            wait_idle();
            check_quiet();
        end

        // Start held through RUN with different operands: ignored until DONE,
        // then accepted in DONE while done still pulses.
        @(negedge clk);
        op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        c = cyc;
        e.prod = 32'd15; e.cyc = c + iters(3) + 1;
        sb.push_back(e);
        @(negedge clk);
        op_a = 32'd11; op_b = 32'd13;
        while (cyc < c + iters(3) + 1) @(negedge clk);
        check("held_done_cycle", 32'(done), 32'd1);
        e.prod = 32'd143; e.cyc = cyc + iters(4) + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; op_a = '0; op_b = '0;
        check("restart_busy", 32'(busy), 32'd1);
        wait_idle();
        check_quiet();

        // Reset in RUN cycle 10: abort with no done pulse.
        @(negedge clk);
        op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
        c = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_own", 32'(alu_own), 32'd0);
        check("abort_product", product, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_pending", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
